// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package pipe_hazard_pkg;

    localparam int RAW = 5;
    localparam int TW  = 2;

    // Bypass-mux select encodings.
    localparam logic [2:0] SEL_RF     = 3'b000;
    localparam logic [2:0] SEL_PC8_E  = 3'b001;
    localparam logic [2:0] SEL_ALU_M  = 3'b010;
    localparam logic [2:0] SEL_HILO_M = 3'b011;
    localparam logic [2:0] SEL_PC8_M  = 3'b100;
    localparam logic [2:0] SEL_WB     = 3'b101;

    // A source operand that is never read carries this Tuse.
    localparam logic [TW-1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_HILO = 2'd1,
        SRC_PC8  = 2'd2,
        SRC_MEM  = 2'd3
    } src_t;

    // Shadow copy of one instruction's hazard-relevant fields.
    typedef struct packed {
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic [RAW-1:0] wa;
        logic [TW-1:0]  tnew;
        src_t           src;
    } stage_t;

    // Priority bypass select for one operand: E (PC8 only) > M (ready) > W > RF.
    // A producer that matches but is not ready falls through to the older stage;
    // the stall logic guarantees such a value is never actually consumed.
    function automatic logic [2:0] fwd_sel(input logic [RAW-1:0] r, input logic use_e,
                                           input stage_t e, input stage_t m, input stage_t w);
        logic [2:0] sel;
        sel = SEL_RF;
        if (r != '0) begin
            if (use_e && r == e.wa && e.src == SRC_PC8 && e.tnew == '0) begin
                sel = SEL_PC8_E;
            end else if (r == m.wa && m.tnew == '0 && m.src != SRC_MEM) begin
                case (m.src)
                    SRC_ALU:  sel = SEL_ALU_M;
                    SRC_HILO: sel = SEL_HILO_M;
                    default:  sel = SEL_PC8_M;
                endcase
            end else if (r == w.wa) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage of hazard info; optional saturating Tnew decrement on load.
// Latency: 1 cycle (register).
// Backpressure: none; bubble loads an empty instruction (wa=0, tnew=0).
module hazard_stage_reg
    import pipe_hazard_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    // Advance one instruction per clock; Tnew counts down toward ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
            if (DEC_TNEW && d.tnew != '0) begin
                q.tnew <= d.tnew - 2'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline (optional HI/LO stall: HAZARD_MD_STALL_EN).
// Latency: 0 cycles, outputs are combinational from shadow stages and D-stage info.
// Backpressure: stall_d holds PC/IF-ID while flush_e injects an E bubble.
module hazard_forward_ctrl
    import pipe_hazard_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RAW-1:0] rs_d,
    input  logic [RAW-1:0] rt_d,
    input  logic [TW-1:0]  tuse_rs_d,
    input  logic [TW-1:0]  tuse_rt_d,
    input  logic [RAW-1:0] wa_d,
    input  logic [TW-1:0]  tnew_d,
    input  logic [1:0]     src_d,
    input  logic           md_use_d,
    input  logic           md_busy_e,
    output logic           stall_d,
    output logic           flush_e,
    output logic [2:0]     sel_rs_d,
    output logic [2:0]     sel_rt_d,
    output logic [2:0]     sel_rs_e,
    output logic [2:0]     sel_rt_e,
    output logic           sel_rt_m
);

    stage_t info_d;
    stage_t st_e;
    stage_t st_m;
    stage_t st_w;
    logic   hz_rs;
    logic   hz_rt;
    logic   stall_any;

    assign info_d = {rs_d, rt_d, wa_d, tnew_d, src_d};

    // Tnew is counted from E entry, so the E stage loads it unchanged.
    hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bubble(stall_any),
        .d     (info_d),
        .q     (st_e)
    );

    hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bubble(1'b0),
        .d     (st_e),
        .q     (st_m)
    );

    hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bubble(1'b0),
        .d     (st_m),
        .q     (st_w)
    );

`ifndef HAZARD_MD_STALL_EN
    // HI/LO ordering is left to software in this build.
    logic md_unused;
    assign md_unused = md_use_d ^ md_busy_e;
`endif

    // Stall when a D operand is needed before its in-flight producer is ready.
    always_comb begin
        hz_rs = (rs_d != '0) &&
                ((rs_d == st_e.wa && tuse_rs_d < st_e.tnew) ||
                 (rs_d == st_m.wa && tuse_rs_d < st_m.tnew));
        hz_rt = (rt_d != '0) &&
                ((rt_d == st_e.wa && tuse_rt_d < st_e.tnew) ||
                 (rt_d == st_m.wa && tuse_rt_d < st_m.tnew));
        stall_any = hz_rs | hz_rt;
`ifdef HAZARD_MD_STALL_EN
        stall_any = stall_any | (md_use_d & md_busy_e);
`endif
    end

    // Bypass selects and stall outputs, forced quiet while reset is asserted.
    always_comb begin
        stall_d  = 1'b0;
        flush_e  = 1'b0;
        sel_rs_d = SEL_RF;
        sel_rt_d = SEL_RF;
        sel_rs_e = SEL_RF;
        sel_rt_e = SEL_RF;
        sel_rt_m = 1'b0;
        if (rst_n) begin
            stall_d  = stall_any;
            flush_e  = stall_any;
            sel_rs_d = fwd_sel(rs_d, 1'b1, st_e, st_m, st_w);
            sel_rt_d = fwd_sel(rt_d, 1'b1, st_e, st_m, st_w);
            sel_rs_e = fwd_sel(st_e.rs, 1'b0, '0, st_m, st_w);
            sel_rt_e = fwd_sel(st_e.rt, 1'b0, '0, st_m, st_w);
            sel_rt_m = (st_m.rt != '0) && (st_m.rt == st_w.wa);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus randomized traffic.
// Latency: outputs sampled on the falling edge, model advanced after each rising edge.
// Backpressure: D inputs are held while the model predicts a stall.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_d, rt_d, wa_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d, src_d;
    logic       md_use_d, md_busy_e;
    logic       stall_d, flush_e, sel_rt_m;
    logic [2:0] sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e;

    int checks = 0;
    int errors = 0;

    hazard_forward_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .wa_d(wa_d), .tnew_d(tnew_d), .src_d(src_d),
        .md_use_d(md_use_d), .md_busy_e(md_busy_e),
        .stall_d(stall_d), .flush_e(flush_e),
        .sel_rs_d(sel_rs_d), .sel_rt_d(sel_rt_d),
        .sel_rs_e(sel_rs_e), .sel_rt_e(sel_rt_e), .sel_rt_m(sel_rt_m)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions, index 0 = E, 1 = M, 2 = W.
    // tnew holds the cycles still remaining at the instruction's current stage.
    typedef struct { int rs; int rt; int wa; int tnew; int src; } mins_t;
    mins_t pipe [3];

    function automatic bit md_stall_enabled();
`ifdef HAZARD_MD_STALL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_hz(int r, int tuse);
        if (r == 0) return 1'b0;
        for (int s = 0; s < 2; s++)
            if (pipe[s].wa == r && tuse < pipe[s].tnew) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = m_hz(int'(rs_d), int'(tuse_rs_d)) || m_hz(int'(rt_d), int'(tuse_rt_d));
        if (md_stall_enabled() && md_use_d && md_busy_e) s = 1'b1;
        return s;
    endfunction

    // Youngest matching producer that can supply the value now; 0 if none.
    // first = 0 searches from E (D operands), first = 1 from M (E operands).
    function automatic int m_fwd(int r, int first);
        if (r == 0) return 0;
        for (int s = first; s < 3; s++) begin
            if (pipe[s].wa == r) begin
                if (s == 0 && pipe[s].src == 2 && pipe[s].tnew == 0) return 1;
                if (s == 1 && pipe[s].tnew == 0 && pipe[s].src != 3) return 2 + pipe[s].src;
                if (s == 2) return 5;
            end
        end
        return 0;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 0};
    endfunction

    task automatic drive_d(input int rs, input int rt, input int tu_rs, input int tu_rt,
                           input int wa, input int tnew, input int src, input bit md);
        rs_d = 5'(rs); rt_d = 5'(rt); tuse_rs_d = 2'(tu_rs); tuse_rt_d = 2'(tu_rt);
        wa_d = 5'(wa); tnew_d = 2'(tnew); src_d = 2'(src); md_use_d = md;
    endtask

    task automatic drive_nop();
        drive_d(0, 0, 3, 3, 0, 0, 0, 1'b0);
    endtask

    // One clock: advance the model exactly as the pipeline should.
    task automatic tick();
        bit s;
        s = m_stall();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_clear();
        end else begin
            pipe[2] = pipe[1];
            pipe[2].tnew = (pipe[1].tnew > 0) ? pipe[1].tnew - 1 : 0;
            pipe[1] = pipe[0];
            pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
            if (s) pipe[0] = '{0, 0, 0, 0, 0};
            else   pipe[0] = '{int'(rs_d), int'(rt_d), int'(wa_d), int'(tnew_d), int'(src_d)};
        end
    endtask

    task automatic drain();
        drive_nop();
        md_busy_e = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        m_clear();
        drive_d(1, 2, 0, 0, 1, 2, 3, 1'b1);
        md_busy_e = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_d, flush_e, sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e, sel_rt_m} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {stall_d, flush_e, sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e, sel_rt_m});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_load_use();
        drain();
        drive_d(29, 0, 1, 3, 8, 2, 3, 1'b0);       // lw $8
        tick();
        drive_d(8, 9, 1, 1, 10, 1, 0, 1'b0);       // addu $10,$8,$9
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b1 || flush_e !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall_d=%0b flush_e=%0b, expected 1/1", stall_d, flush_e);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: stall_d=%0b, expected 0", stall_d);
        end
        tick();
        drive_nop();
        @(negedge clk);
        checks++;
        if (sel_rs_e !== 3'b101 || sel_rt_e !== 3'b000) begin
            errors++;
            $display("FAIL load_use_fwd_e: sel_rs_e=%b sel_rt_e=%b, expected 101/000", sel_rs_e, sel_rt_e);
        end
        tick();
    endtask

    task automatic test_branch();
        drain();
        drive_d(0, 0, 3, 3, 9, 1, 0, 1'b0);        // addu $9
        tick();
        drive_d(9, 0, 0, 3, 0, 0, 0, 1'b0);        // beq $9,$0
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b1) begin
            errors++;
            $display("FAIL branch_stall: stall_d=%0b, expected 1", stall_d);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0 || sel_rs_d !== 3'b010) begin
            errors++;
            $display("FAIL branch_fwd_m: stall_d=%0b sel_rs_d=%b, expected 0/010", stall_d, sel_rs_d);
        end
        tick();
    endtask

    task automatic test_jal_jr();
        drain();
        drive_d(0, 0, 3, 3, 31, 0, 2, 1'b0);       // jal
        tick();
        drive_d(31, 0, 0, 3, 0, 0, 0, 1'b0);       // jr $31
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0 || sel_rs_d !== 3'b001) begin
            errors++;
            $display("FAIL jal_jr: stall_d=%0b sel_rs_d=%b, expected 0/001", stall_d, sel_rs_d);
        end
        tick();
    endtask

    task automatic test_m_over_w();
        drain();
        drive_d(0, 0, 3, 3, 2, 1, 0, 1'b0);        // addu $2 (older)
        tick();
        drive_d(0, 0, 3, 3, 2, 1, 0, 1'b0);        // addu $2 (younger)
        tick();
        drive_d(2, 0, 1, 1, 0, 1, 0, 1'b0);        // addu $0,$2,$0
        tick();
        drive_d(0, 0, 0, 0, 0, 0, 0, 1'b0);        // reads $0 right after a $0 write
        @(negedge clk);
        checks++;
        if (sel_rs_e !== 3'b010 || sel_rt_e !== 3'b000) begin
            errors++;
            $display("FAIL m_over_w: sel_rs_e=%b sel_rt_e=%b, expected 010/000", sel_rs_e, sel_rt_e);
        end
        checks++;
        if (stall_d !== 1'b0 || sel_rs_d !== 3'b000 || sel_rt_d !== 3'b000) begin
            errors++;
            $display("FAIL reg0_no_fwd: stall_d=%0b sel_rs_d=%b sel_rt_d=%b, expected 0/000/000",
                     stall_d, sel_rs_d, sel_rt_d);
        end
        tick();
    endtask

    task automatic test_store_data();
        drain();
        drive_d(29, 0, 1, 3, 5, 2, 3, 1'b0);       // lw $5
        tick();
        drive_d(29, 5, 1, 2, 0, 0, 0, 1'b0);       // sw $5
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL store_no_stall: stall_d=%0b, expected 0", stall_d);
        end
        tick();
        drive_nop();
        tick();
        @(negedge clk);
        checks++;
        if (sel_rt_m !== 1'b1) begin
            errors++;
            $display("FAIL store_fwd_w: sel_rt_m=%0b, expected 1", sel_rt_m);
        end
        tick();
        @(negedge clk);
        checks++;
        if (sel_rt_m !== 1'b0) begin
            errors++;
            $display("FAIL store_fwd_idle: sel_rt_m=%0b, expected 0", sel_rt_m);
        end
        tick();
    endtask

    task automatic test_md_stall();
        drain();
        drive_d(0, 0, 3, 3, 4, 1, 1, 1'b1);        // mfhi $4
        md_busy_e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (stall_d !== md_stall_enabled() || flush_e !== md_stall_enabled()) begin
                errors++;
                $display("FAIL md_busy_stall: stall_d=%0b flush_e=%0b, expected %0b",
                         stall_d, flush_e, md_stall_enabled());
            end
            tick();
        end
        md_busy_e = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL md_idle_release: stall_d=%0b, expected 0", stall_d);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drain();
        drive_d(0, 0, 3, 3, 3, 1, 0, 1'b0);
        tick();
        drive_d(3, 3, 1, 1, 3, 1, 0, 1'b0);
        tick();
        drive_d(3, 3, 0, 0, 0, 0, 0, 1'b1);        // would stall and forward
        md_busy_e = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_d, flush_e, sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e, sel_rt_m} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, expected all zero",
                     {stall_d, flush_e, sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e, sel_rt_m});
        end
        tick();
        rst_n = 1'b1;
        md_busy_e = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0 || sel_rs_d !== 3'b000 || sel_rt_d !== 3'b000 || sel_rs_e !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_stale: stall_d=%0b sel_rs_d=%b sel_rt_d=%b sel_rs_e=%b, expected 0/000/000/000",
                     stall_d, sel_rs_d, sel_rt_d, sel_rs_e);
        end
        tick();
    endtask

    task automatic test_random();
        bit held;
        bit exp_stall;
        int src;
        int tn;
        held = 1'b0;
        drain();
        for (int i = 0; i < 600; i++) begin
            if (!held) begin
                src = $urandom_range(0, 3);
                case (src)
                    0: tn = $urandom_range(0, 1);
                    1: tn = 1;
                    2: tn = 0;
                    default: tn = 2;
                endcase
                drive_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), tn, src,
                        ($urandom_range(0, 3) == 0));
            end
            md_busy_e = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            exp_stall = m_stall();
            checks++;
            if (stall_d !== exp_stall || flush_e !== exp_stall) begin
                errors++;
                $display("FAIL rnd_stall cyc %0d: stall_d=%0b flush_e=%0b, expected %0b", i, stall_d, flush_e, exp_stall);
            end
            checks++;
            if (sel_rs_d !== 3'(m_fwd(int'(rs_d), 0)) || sel_rt_d !== 3'(m_fwd(int'(rt_d), 0))) begin
                errors++;
                $display("FAIL rnd_sel_d cyc %0d: rs=%b rt=%b, expected %0d/%0d", i, sel_rs_d, sel_rt_d,
                         m_fwd(int'(rs_d), 0), m_fwd(int'(rt_d), 0));
            end
            checks++;
            if (sel_rs_e !== 3'(m_fwd(pipe[0].rs, 1)) || sel_rt_e !== 3'(m_fwd(pipe[0].rt, 1))) begin
                errors++;
                $display("FAIL rnd_sel_e cyc %0d: rs=%b rt=%b, expected %0d/%0d", i, sel_rs_e, sel_rt_e,
                         m_fwd(pipe[0].rs, 1), m_fwd(pipe[0].rt, 1));
            end
            checks++;
            if (sel_rt_m !== (pipe[1].rt != 0 && pipe[1].rt == pipe[2].wa)) begin
                errors++;
                $display("FAIL rnd_sel_m cyc %0d: sel_rt_m=%0b, expected %0b", i, sel_rt_m,
                         (pipe[1].rt != 0 && pipe[1].rt == pipe[2].wa));
            end
            held = exp_stall;
            tick();
        end
    endtask

    initial begin
        drive_nop();
        md_busy_e = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_m_over_w();
        test_store_data();
        test_md_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
